mem_wb_stage: RTL and testbench
===============================

# mem_wb_stage

Parametrised MEM/WB pipeline stage for the in-order core. It holds one instruction between the memory stage and the register file, and waits for the load response. A response that arrives while writeback is stalled is captured in a one-entry hold register. Responses for any number of flushed loads, up to MAX_DROP, are discarded. Load data is aligned and sign- or zero-extended by func3, so the register file receives final write data.

## Interface
Parameters:
- DATA_WIDTH, 32, register/load data width; legal values 32 or 64
- ADDR_WIDTH, 32, width of address/ALU-result field
- RD_WIDTH, 5, destination register index width
- MAX_DROP, 2, maximum outstanding flushed-load responses tracked; drop counter width is clog2(MAX_DROP+1)

Ports (clock and reset first; one clock; reset is asynchronous and active-low):
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- hold  in  1  global stall; blocks retirement
- flush  in  1  kill held instruction and block capture this cycle
- valid_mem  in  1  MEM stage holds a valid instruction
- ready_go_mem  in  1  MEM instruction may advance
- allow_in_wb  out  1  stage accepts a new instruction this cycle
- mem_address_i  in  ADDR_WIDTH  load address, or ALU result for non-loads
- rd_mem  in  RD_WIDTH  destination register
- control_flow_i  in  2  bit1 = load (mem2reg), bit0 = write register
- ins_func3_i  in  3  load size/sign code
- mem_data_ok  in  1  memory read response strobe
- mem_read_data_i  in  DATA_WIDTH  raw response data (full aligned word)
- allow_in_regfile  in  1  register file side can take retirement
- valid_wb  out  1  held instruction valid
- ready_go_wb  out  1  held instruction complete
- write_reg  out  1  register file write enable
- rd_wb  out  RD_WIDTH  write index
- wb_data  out  DATA_WIDTH  formatted write data
- mem2reg  out  1  held instruction is a load (valid-qualified)
- err_spurious  out  1  one-cycle pulse on unexpected response
- err_drop_ovf  out  1  one-cycle pulse on drop-counter saturation

## Operation
- State: valid, data_valid, drop_cnt, hold_data, and payload registers (addr, rd, control_flow, func3).
- is_load = control_flow[1]. A live response (live_ok) is mem_data_ok with drop_cnt == 0.
- ready_go_wb = valid & (~is_load | data_valid | live_ok).
- retire = ready_go_wb & allow_in_regfile & ~hold.
- allow_in_wb = ~valid | retire.
- pipe_valid = valid_mem & ready_go_mem & ~flush.
- Capture: when allow_in_wb, valid <= pipe_valid and data_valid <= 0. Payload is loaded only if pipe_valid.
- Response capture: if valid & is_load & ~data_valid & live_ok & ~retire & ~flush, then hold_data <= mem_read_data_i and data_valid <= 1.
- Flush: valid <= 0 and data_valid <= 0.
  - If the held load is still waiting (valid & is_load & ~data_valid & ~live_ok), drop_cnt increments.
- Drop: mem_data_ok with drop_cnt > 0 decrements drop_cnt; the data is ignored.
  - A simultaneous increment and decrement leaves drop_cnt unchanged.
- Saturation: if an increment would exceed MAX_DROP, drop_cnt stays at MAX_DROP and err_drop_ovf pulses.
- Spurious response: live_ok with no valid, waiting load pulses err_spurious; the response is ignored.
- Formatting, with src = data_valid ? hold_data : mem_read_data_i and byte lane from addr low bits:
  - 000 LB: sign-extend byte
  - 001 LH: sign-extend half
  - 010 LW: word, sign-extended when DATA_WIDTH = 64
  - 011 LD: 64 only
  - 100 LBU: zero-extend byte
  - 101 LHU: zero-extend half
  - 110 LWU: 64 only
  - Other codes pass src unchanged.
- wb_data = is_load ? formatted : zero-extended addr.
- write_reg = valid & control_flow[0] & ready_go_wb.
- mem2reg = valid & is_load.
- rd_wb = rd.

## Timing
- Reset values: valid 0, data_valid 0, drop_cnt 0, payload registers 0.
  - allow_in_wb 1; valid_wb, ready_go_wb, write_reg, mem2reg, err_* 0; wb_data 0; rd_wb 0.
- Reset mid-operation clears all state at once. Any later response is treated as spurious.
- Instruction accepted at edge N is valid_wb from N+1.
- A non-load is ready in the same cycle it becomes valid.
- A load response reaches wb_data combinationally in its arrival cycle; the hold register adds no latency.
- Back-to-back throughput is one instruction per cycle when allow_in_regfile = 1 and hold = 0.
- Flush wins over capture and over response capture in the same cycle.

## Test plan
- Non-load: ALU result 0x1234 to rd 5, no stall -> valid_wb at N+1; write_reg = 1, wb_data = 0x1234, rd_wb = 5; allow_in_wb stays 1.
- LB at addr 0x...3, response 0x80FF_FF00 at N+3 -> ready_go_wb and write_reg asserted at N+3 only; wb_data = 0xFFFF_FF80.
- LHU, response arrives while hold = 1 -> data_valid set; two stall cycles; on release wb_data = zero-extended half; allow_in_wb 0 throughout the stall.
- Flush a waiting load, then a new LW -> drop_cnt = 1; the first mem_data_ok is dropped; the second response is written; no err pulse.
- Flush three waiting loads with no responses (MAX_DROP = 2) -> drop_cnt saturates at 2; err_drop_ovf pulses once.
- mem_data_ok with the stage empty -> err_spurious pulses one cycle; no write_reg; state unchanged.

Source files
------------

// File: rtl/mem_wb_stage_if.sv
// MEM -> WB bus: instruction handoff plus the load response channel.
// The MEM side drives the master modport, and the writeback stage uses the slave modport.
interface mem_wb_stage_if #(
   parameter int DATA_WIDTH = 32,
   parameter int ADDR_WIDTH = 32,
   parameter int RD_WIDTH   = 5
);
   logic                  valid_mem;
   logic                  ready_go_mem;
   logic                  allow_in_wb;
   logic [ADDR_WIDTH-1:0] mem_address_i;
   logic [RD_WIDTH-1:0]   rd_mem;
   logic [1:0]            control_flow_i;
   logic [2:0]            ins_func3_i;
   logic                  mem_data_ok;
   logic [DATA_WIDTH-1:0] mem_read_data_i;

   modport master (
      output valid_mem, ready_go_mem, mem_address_i, rd_mem, control_flow_i,
             ins_func3_i, mem_data_ok, mem_read_data_i,
      input  allow_in_wb
   );

   modport slave (
      input  valid_mem, ready_go_mem, mem_address_i, rd_mem, control_flow_i,
             ins_func3_i, mem_data_ok, mem_read_data_i,
      output allow_in_wb
   );
endinterface

// File: rtl/mem_wb_stage.sv
// MEM/WB stage: holds one instruction, waits for its load response, and discards responses
// that belong to flushed loads. It also formats load data for the register file.
module mem_wb_stage #(
   parameter int DATA_WIDTH = 32,
   parameter int ADDR_WIDTH = 32,
   parameter int RD_WIDTH   = 5,
   parameter int MAX_DROP   = 2
) (
   input  logic                  clk,
   input  logic                  rst_n,
   mem_wb_stage_if.slave         mem_if,
   input  logic                  hold,
   input  logic                  flush,
   input  logic                  allow_in_regfile,
   output logic                  valid_wb,
   output logic                  ready_go_wb,
   output logic                  write_reg,
   output logic [RD_WIDTH-1:0]   rd_wb,
   output logic [DATA_WIDTH-1:0] wb_data,
   output logic                  mem2reg,
   output logic                  err_spurious,
   output logic                  err_drop_ovf
);
   localparam int DROP_W = $clog2(MAX_DROP + 1);
   localparam int OFF_W  = $clog2(DATA_WIDTH / 8);
   localparam logic [DROP_W-1:0] DROP_MAX = DROP_W'(MAX_DROP);

   logic                  valid_q, valid_d;
   logic                  data_valid_q, data_valid_d;
   logic [DROP_W-1:0]     drop_cnt_q, drop_cnt_d;
   logic [DATA_WIDTH-1:0] hold_data_q, hold_data_d;
   logic [ADDR_WIDTH-1:0] addr_q, addr_d;
   logic [RD_WIDTH-1:0]   rd_q, rd_d;
   logic [1:0]            cf_q, cf_d;
   logic [2:0]            func3_q, func3_d;

   logic is_load, live_ok, waiting, retire, allow_in, pipe_valid;
   logic drop_inc, drop_dec;

   assign is_load     = cf_q[1];
   assign live_ok     = mem_if.mem_data_ok & (drop_cnt_q == '0);
   assign waiting     = valid_q & is_load & ~data_valid_q;
   assign ready_go_wb = valid_q & (~is_load | data_valid_q | live_ok);
   assign retire      = ready_go_wb & allow_in_regfile & ~hold;
   assign allow_in    = ~valid_q | retire;
   assign pipe_valid  = mem_if.valid_mem & mem_if.ready_go_mem & ~flush;

   // A flushed load whose response arrives in the same cycle has consumed it, so it owes nothing.
   assign drop_inc     = flush & waiting & ~live_ok;
   assign drop_dec     = mem_if.mem_data_ok & (drop_cnt_q != '0);
   assign err_drop_ovf = drop_inc & ~drop_dec & (drop_cnt_q == DROP_MAX);
   assign err_spurious = live_ok & ~waiting;

   always_comb begin
      valid_d      = valid_q;
      data_valid_d = data_valid_q;
      hold_data_d  = hold_data_q;
      addr_d       = addr_q;
      rd_d         = rd_q;
      cf_d         = cf_q;
      func3_d      = func3_q;
      drop_cnt_d   = drop_cnt_q;

      if (flush) begin
         valid_d      = 1'b0;
         data_valid_d = 1'b0;
      end else if (allow_in) begin
         valid_d      = pipe_valid;
         data_valid_d = 1'b0;
         if (pipe_valid) begin
            addr_d  = mem_if.mem_address_i;
            rd_d    = mem_if.rd_mem;
            cf_d    = mem_if.control_flow_i;
            func3_d = mem_if.ins_func3_i;
         end
      end else if (waiting & live_ok) begin
         hold_data_d  = mem_if.mem_read_data_i;
         data_valid_d = 1'b1;
      end

      if (drop_inc & ~drop_dec & (drop_cnt_q != DROP_MAX)) begin
         drop_cnt_d = drop_cnt_q + 1'b1;
      end else if (drop_dec & ~drop_inc) begin
         drop_cnt_d = drop_cnt_q - 1'b1;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         valid_q      <= 1'b0;
         data_valid_q <= 1'b0;
         drop_cnt_q   <= '0;
         hold_data_q  <= '0;
         addr_q       <= '0;
         rd_q         <= '0;
         cf_q         <= '0;
         func3_q      <= '0;
      end else begin
         valid_q      <= valid_d;
         data_valid_q <= data_valid_d;
         drop_cnt_q   <= drop_cnt_d;
         hold_data_q  <= hold_data_d;
         addr_q       <= addr_d;
         rd_q         <= rd_d;
         cf_q         <= cf_d;
         func3_q      <= func3_d;
      end
   end

   logic [DATA_WIDTH-1:0] src, fmt;
   logic [OFF_W-1:0]      off, half_off, word_off;
   logic [7:0]            byte_v;
   logic [15:0]           half_v;
   logic [31:0]           word_v;

   // Lane selection ignores the low address bits below each access size (natural alignment).
   assign src      = data_valid_q ? hold_data_q : mem_if.mem_read_data_i;
   assign off      = addr_q[OFF_W-1:0];
   assign half_off = off & ~OFF_W'(1);
   assign word_off = off & ~OFF_W'(3);
   assign byte_v   = 8'(src >> {off, 3'b000});
   assign half_v   = 16'(src >> {half_off, 3'b000});
   assign word_v   = 32'(src >> {word_off, 3'b000});

   always_comb begin
      fmt = src;
      case (func3_q)
         3'b000:  fmt = DATA_WIDTH'($signed(byte_v));
         3'b001:  fmt = DATA_WIDTH'($signed(half_v));
         3'b010:  fmt = DATA_WIDTH'($signed(word_v));
         3'b100:  fmt = DATA_WIDTH'(byte_v);
         3'b101:  fmt = DATA_WIDTH'(half_v);
         3'b110:  fmt = DATA_WIDTH'(word_v);
         default: fmt = src;
      endcase
   end

   assign wb_data            = is_load ? fmt : DATA_WIDTH'(addr_q);
   assign write_reg          = valid_q & cf_q[0] & ready_go_wb;
   assign mem2reg            = valid_q & is_load;
   assign valid_wb           = valid_q;
   assign rd_wb              = rd_q;
   assign mem_if.allow_in_wb = allow_in;
endmodule

// File: tb/tb_mem_wb_stage.sv
// Directed scenarios plus a randomized run checked against a cycle-level behavioural model.
module tb_mem_wb_stage;
   localparam int DW = 32, AW = 32, RW = 5, MD = 2;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   logic hold, flush, arf;
   logic valid_wb, ready_go_wb, write_reg, mem2reg, err_spurious, err_drop_ovf;
   logic [RW-1:0] rd_wb;
   logic [DW-1:0] wb_data;
   int n_cmp = 0;
   int n_err = 0;

   always #5 clk = ~clk;

   mem_wb_stage_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .RD_WIDTH(RW)) mif ();

   mem_wb_stage #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .RD_WIDTH(RW), .MAX_DROP(MD)) dut (
      .clk(clk), .rst_n(rst_n), .mem_if(mif), .hold(hold), .flush(flush),
      .allow_in_regfile(arf), .valid_wb(valid_wb), .ready_go_wb(ready_go_wb),
      .write_reg(write_reg), .rd_wb(rd_wb), .wb_data(wb_data), .mem2reg(mem2reg),
      .err_spurious(err_spurious), .err_drop_ovf(err_drop_ovf)
   );

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic idle();
      mif.valid_mem = 0; mif.ready_go_mem = 1; mif.mem_address_i = '0; mif.rd_mem = '0;
      mif.control_flow_i = '0; mif.ins_func3_i = '0; mif.mem_data_ok = 0;
      mif.mem_read_data_i = '0; hold = 0; flush = 0; arf = 1;
   endtask

   task automatic issue(input logic [31:0] a, input logic [4:0] r, input logic [1:0] c,
                        input logic [2:0] f);
      mif.valid_mem = 1; mif.ready_go_mem = 1; mif.mem_address_i = a; mif.rd_mem = r;
      mif.control_flow_i = c; mif.ins_func3_i = f;
   endtask

   // Load result straight from the ISA definition of each func3 code.
   function automatic logic [31:0] ref_fmt(input logic [31:0] s, input logic [31:0] a,
                                           input logic [2:0] f);
      logic [7:0]  b;
      logic [15:0] h;
      b = s[8*a[1:0] +: 8];
      h = a[1] ? s[31:16] : s[15:0];
      case (f)
         3'd0:    return {{24{b[7]}}, b};
         3'd1:    return {{16{h[15]}}, h};
         3'd4:    return {24'd0, b};
         3'd5:    return {16'd0, h};
         default: return s;
      endcase
   endfunction

   task automatic test_reset();
      idle();
      rst_n = 0;
      #2;
      n_cmp++; if (mif.allow_in_wb !== 1'b1) begin n_err++; $display("FAIL reset_allow: got %b want 1", mif.allow_in_wb); end
      n_cmp++; if ({valid_wb, ready_go_wb, write_reg, mem2reg} !== 4'b0) begin n_err++; $display("FAIL reset_flags: got %b want 0000", {valid_wb, ready_go_wb, write_reg, mem2reg}); end
      n_cmp++; if ({err_spurious, err_drop_ovf} !== 2'b0) begin n_err++; $display("FAIL reset_err: got %b want 00", {err_spurious, err_drop_ovf}); end
      n_cmp++; if (wb_data !== 32'h0 || rd_wb !== 5'd0) begin n_err++; $display("FAIL reset_data: got %h/%0d want 0/0", wb_data, rd_wb); end
      cyc(); cyc();
      rst_n = 1;
   endtask

   task automatic test_nonload();
      issue(32'h1234, 5'd5, 2'b01, 3'd0);
      #4;
      n_cmp++; if (valid_wb !== 1'b0 || mif.allow_in_wb !== 1'b1) begin n_err++; $display("FAIL nl_pre: got v=%b a=%b want v=0 a=1", valid_wb, mif.allow_in_wb); end
      cyc(); idle(); #4;
      n_cmp++; if (valid_wb !== 1'b1 || write_reg !== 1'b1 || ready_go_wb !== 1'b1) begin n_err++; $display("FAIL nl_flags: got v=%b w=%b r=%b want 111", valid_wb, write_reg, ready_go_wb); end
      n_cmp++; if (wb_data !== 32'h1234 || rd_wb !== 5'd5) begin n_err++; $display("FAIL nl_data: got %h/%0d want 1234/5", wb_data, rd_wb); end
      n_cmp++; if (mif.allow_in_wb !== 1'b1 || mem2reg !== 1'b0) begin n_err++; $display("FAIL nl_allow: got a=%b m=%b want a=1 m=0", mif.allow_in_wb, mem2reg); end
      cyc(); #4;
      n_cmp++; if (valid_wb !== 1'b0) begin n_err++; $display("FAIL nl_retired: got %b want 0", valid_wb); end
      cyc();
   endtask

   task automatic test_lb();
      issue(32'h1003, 5'd7, 2'b11, 3'd0);
      cyc(); idle();
      for (int i = 1; i <= 2; i++) begin
         #4;
         n_cmp++; if ({valid_wb, mem2reg, ready_go_wb, write_reg, mif.allow_in_wb} !== 5'b11000) begin n_err++; $display("FAIL lb_wait%0d: got %b want 11000", i, {valid_wb, mem2reg, ready_go_wb, write_reg, mif.allow_in_wb}); end
         cyc();
      end
      mif.mem_data_ok = 1; mif.mem_read_data_i = 32'h80FF_FF00;
      #4;
      n_cmp++; if (ready_go_wb !== 1'b1 || write_reg !== 1'b1) begin n_err++; $display("FAIL lb_resp: got r=%b w=%b want 11", ready_go_wb, write_reg); end
      n_cmp++; if (wb_data !== 32'hFFFF_FF80 || rd_wb !== 5'd7) begin n_err++; $display("FAIL lb_data: got %h/%0d want ffffff80/7", wb_data, rd_wb); end
      cyc(); idle(); #4;
      n_cmp++; if (valid_wb !== 1'b0 || err_spurious !== 1'b0) begin n_err++; $display("FAIL lb_after: got v=%b s=%b want 00", valid_wb, err_spurious); end
      cyc();
   endtask

   task automatic test_lhu_stall();
      issue(32'h2002, 5'd9, 2'b11, 3'd5);
      cyc(); idle();
      hold = 1; mif.mem_data_ok = 1; mif.mem_read_data_i = 32'hABCD_1234;
      #4;
      n_cmp++; if (ready_go_wb !== 1'b1 || mif.allow_in_wb !== 1'b0 || wb_data !== 32'h0000_ABCD) begin n_err++; $display("FAIL lhu_arrive: got r=%b a=%b d=%h want 1/0/0000abcd", ready_go_wb, mif.allow_in_wb, wb_data); end
      cyc();
      mif.mem_data_ok = 0; mif.mem_read_data_i = 32'h5555_AAAA;
      for (int i = 0; i < 2; i++) begin
         #4;
         n_cmp++; if (ready_go_wb !== 1'b1 || mif.allow_in_wb !== 1'b0 || wb_data !== 32'h0000_ABCD) begin n_err++; $display("FAIL lhu_stall%0d: got r=%b a=%b d=%h want 1/0/0000abcd", i, ready_go_wb, mif.allow_in_wb, wb_data); end
         cyc();
      end
      hold = 0;
      #4;
      n_cmp++; if (write_reg !== 1'b1 || mif.allow_in_wb !== 1'b1 || wb_data !== 32'h0000_ABCD) begin n_err++; $display("FAIL lhu_release: got w=%b a=%b d=%h want 1/1/0000abcd", write_reg, mif.allow_in_wb, wb_data); end
      cyc(); #4;
      n_cmp++; if (valid_wb !== 1'b0) begin n_err++; $display("FAIL lhu_after: got %b want 0", valid_wb); end
      cyc();
   endtask

   task automatic test_flush_drop();
      issue(32'h3000, 5'd3, 2'b11, 3'd2);
      cyc(); idle();
      flush = 1;
      #4;
      n_cmp++; if ({err_spurious, err_drop_ovf} !== 2'b00) begin n_err++; $display("FAIL fd_flush_err: got %b want 00", {err_spurious, err_drop_ovf}); end
      cyc(); flush = 0;
      issue(32'h3004, 5'd4, 2'b11, 3'd2);
      #4;
      n_cmp++; if (valid_wb !== 1'b0 || mif.allow_in_wb !== 1'b1) begin n_err++; $display("FAIL fd_empty: got v=%b a=%b want 0/1", valid_wb, mif.allow_in_wb); end
      cyc(); idle();
      mif.mem_data_ok = 1; mif.mem_read_data_i = 32'h1111_1111;
      #4;
      n_cmp++; if ({ready_go_wb, write_reg, err_spurious} !== 3'b000) begin n_err++; $display("FAIL fd_dropped: got %b want 000", {ready_go_wb, write_reg, err_spurious}); end
      cyc();
      mif.mem_read_data_i = 32'h2222_2222;
      #4;
      n_cmp++; if (write_reg !== 1'b1 || wb_data !== 32'h2222_2222 || err_spurious !== 1'b0) begin n_err++; $display("FAIL fd_live: got w=%b d=%h s=%b want 1/22222222/0", write_reg, wb_data, err_spurious); end
      cyc(); idle(); #4;
      n_cmp++; if (valid_wb !== 1'b0) begin n_err++; $display("FAIL fd_after: got %b want 0", valid_wb); end
      cyc();
   endtask

   task automatic test_drop_sat();
      for (int k = 0; k < 3; k++) begin
         issue(32'h4000 + 32'(k * 4), 5'd1, 2'b11, 3'd2);
         cyc(); idle();
         flush = 1;
         #4;
         n_cmp++; if (err_drop_ovf !== (k == 2)) begin n_err++; $display("FAIL sat_ovf%0d: got %b want %b", k, err_drop_ovf, k == 2); end
         cyc(); flush = 0;
      end
      mif.mem_data_ok = 1;
      for (int k = 0; k < 2; k++) begin
         #4;
         n_cmp++; if (err_spurious !== 1'b0 || err_drop_ovf !== 1'b0) begin n_err++; $display("FAIL sat_drain%0d: got s=%b o=%b want 00", k, err_spurious, err_drop_ovf); end
         cyc();
      end
      #4;
      n_cmp++; if (err_spurious !== 1'b1) begin n_err++; $display("FAIL sat_empty_resp: got %b want 1", err_spurious); end
      cyc(); idle();
   endtask

   task automatic test_spurious();
      mif.mem_data_ok = 1; mif.mem_read_data_i = 32'hDEAD_BEEF;
      #4;
      n_cmp++; if ({err_spurious, write_reg, valid_wb, mif.allow_in_wb} !== 4'b1001) begin n_err++; $display("FAIL spur_pulse: got %b want 1001", {err_spurious, write_reg, valid_wb, mif.allow_in_wb}); end
      cyc(); mif.mem_data_ok = 0; #4;
      n_cmp++; if (err_spurious !== 1'b0 || valid_wb !== 1'b0) begin n_err++; $display("FAIL spur_after: got s=%b v=%b want 00", err_spurious, valid_wb); end
      cyc();
   endtask

   task automatic test_reset_mid();
      issue(32'h5000, 5'd2, 2'b11, 3'd2);
      cyc(); idle(); flush = 1;
      cyc(); flush = 0;
      issue(32'h5004, 5'd2, 2'b11, 3'd2);
      cyc(); idle();
      #2 rst_n = 0;
      #1;
      n_cmp++; if ({valid_wb, mem2reg, mif.allow_in_wb} !== 3'b001) begin n_err++; $display("FAIL rmid_async: got %b want 001", {valid_wb, mem2reg, mif.allow_in_wb}); end
      cyc(); rst_n = 1;
      mif.mem_data_ok = 1;
      #4;
      n_cmp++; if (err_spurious !== 1'b1) begin n_err++; $display("FAIL rmid_spur: got %b want 1", err_spurious); end
      cyc(); idle();
   endtask

   task automatic test_back_to_back();
      for (int i = 0; i < 5; i++) begin
         if (i < 4) issue(32'h100 + 32'(i), 5'(i + 1), 2'b01, 3'd0);
         else idle();
         #4;
         if (i > 0) begin
            n_cmp++; if (valid_wb !== 1'b1 || write_reg !== 1'b1 || mif.allow_in_wb !== 1'b1) begin n_err++; $display("FAIL b2b_flags%0d: got v=%b w=%b a=%b want 111", i, valid_wb, write_reg, mif.allow_in_wb); end
            n_cmp++; if (wb_data !== 32'h100 + 32'(i - 1) || rd_wb !== 5'(i)) begin n_err++; $display("FAIL b2b_data%0d: got %h/%0d want %h/%0d", i, wb_data, rd_wb, 32'h100 + 32'(i - 1), i); end
         end
         cyc();
      end
   endtask

   task automatic test_random();
      logic m_valid, m_got, vm, rg, ok;
      logic [31:0] m_held, m_addr, rdata, e_wb;
      logic [4:0] m_rd;
      logic [1:0] m_cf;
      logic [2:0] m_f3;
      int m_drop;
      logic live, waiting, e_ready, e_write, retire, e_allow, e_spur, inc, dec, e_ovf;

      idle();
      rst_n = 0; cyc(); rst_n = 1;
      m_valid = 0; m_got = 0; m_held = 0; m_addr = 0; m_rd = 0; m_cf = 0; m_f3 = 0; m_drop = 0;
      for (int c = 0; c < 600; c++) begin
         vm = ($urandom_range(0, 9) < 6); rg = ($urandom_range(0, 9) < 8);
         ok = ($urandom_range(0, 9) < 4); rdata = $urandom;
         mif.valid_mem = vm; mif.ready_go_mem = rg; mif.mem_address_i = $urandom;
         mif.rd_mem = 5'($urandom); mif.control_flow_i = 2'($urandom);
         mif.ins_func3_i = 3'($urandom); mif.mem_data_ok = ok; mif.mem_read_data_i = rdata;
         hold = ($urandom_range(0, 9) < 2); flush = ($urandom_range(0, 9) < 1);
         arf = ($urandom_range(0, 9) < 8);

         live    = ok && (m_drop == 0);
         waiting = m_valid && m_cf[1] && !m_got;
         e_ready = m_valid && (!m_cf[1] || m_got || live);
         e_write = e_ready && m_cf[0];
         retire  = e_ready && arf && !hold;
         e_allow = !m_valid || retire;
         e_spur  = live && !waiting;
         inc     = flush && waiting && !live;
         dec     = ok && (m_drop > 0);
         e_ovf   = inc && !dec && (m_drop == MD);
         e_wb    = m_cf[1] ? ref_fmt(m_got ? m_held : rdata, m_addr, m_f3) : m_addr;
         #4;
         n_cmp++; if ({valid_wb, ready_go_wb, write_reg, mif.allow_in_wb, mem2reg} !== {m_valid, e_ready, e_write, e_allow, m_valid && m_cf[1]}) begin n_err++; $display("FAIL rnd_flags c=%0d: got %b want %b", c, {valid_wb, ready_go_wb, write_reg, mif.allow_in_wb, mem2reg}, {m_valid, e_ready, e_write, e_allow, m_valid && m_cf[1]}); end
         n_cmp++; if (wb_data !== e_wb || rd_wb !== m_rd) begin n_err++; $display("FAIL rnd_data c=%0d: got %h/%0d want %h/%0d", c, wb_data, rd_wb, e_wb, m_rd); end
         n_cmp++; if ({err_spurious, err_drop_ovf} !== {e_spur, e_ovf}) begin n_err++; $display("FAIL rnd_err c=%0d: got %b want %b", c, {err_spurious, err_drop_ovf}, {e_spur, e_ovf}); end

         if (flush) begin
            m_valid = 0; m_got = 0;
         end else if (e_allow) begin
            m_valid = vm && rg; m_got = 0;
            if (m_valid) begin
               m_addr = mif.mem_address_i; m_rd = mif.rd_mem;
               m_cf = mif.control_flow_i; m_f3 = mif.ins_func3_i;
            end
         end else if (waiting && live) begin
            m_got = 1; m_held = rdata;
         end
         if (inc && !dec) m_drop = (m_drop == MD) ? MD : m_drop + 1;
         else if (dec && !inc) m_drop = m_drop - 1;
         cyc();
      end
      idle();
   endtask

   initial begin
      test_reset();
      test_nonload();
      test_lb();
      test_lhu_stall();
      test_flush_drop();
      test_drop_sat();
      test_spurious();
      test_reset_mid();
      test_back_to_back();
      test_random();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation exceeded time limit");
      $fatal(1);
   end
endmodule
